// File: rtl/up_memory_pkg.sv
// up_memory_pkg: shared constants and types for the up_memory_mp program/data
// memory. Holds the default word/address widths, the boot-image length and the
// two-state initialisation FSM encoding.
package up_memory_pkg;
  localparam int DW_DEF   = 8;   // default data word width
  localparam int AW_DEF   = 8;   // default address width (DEPTH = 2**AW)
  localparam int BOOT_LEN = 64;  // words in the boot image ROM

  typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/up_memory_rom.sv
// up_memory_rom: combinational boot-image ROM, indexed by the init counter.
// Ports:
//   i_idx  in  AW+1  init counter value
//   o_word out DW    boot word at i_idx, 0 beyond the image
module up_memory_rom
  import up_memory_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic [AW:0]   i_idx,
  output logic [DW-1:0] o_word
);
  localparam int SW = $clog2(BOOT_LEN);

  localparam logic [7:0] IMG [BOOT_LEN] = '{
    8'h75, 8'h5C, 8'h69, 8'h7F, 8'hD5, 8'h69, 8'h3A, 8'h12,
    8'hE4, 8'h07, 8'h9B, 8'h41, 8'hC8, 8'h2D, 8'hF0, 8'h56,
    8'h88, 8'h1E, 8'hA3, 8'h64, 8'h0B, 8'hD9, 8'h37, 8'h72,
    8'h5F, 8'hC1, 8'h26, 8'hB4, 8'h4A, 8'h93, 8'hE8, 8'h0D,
    8'h61, 8'hFA, 8'h17, 8'h8C, 8'h3E, 8'hA0, 8'h55, 8'hCB,
    8'h29, 8'h76, 8'hD2, 8'h04, 8'hBF, 8'h48, 8'h9E, 8'h13,
    8'h6A, 8'hF5, 8'h31, 8'h87, 8'hDC, 8'h20, 8'h4E, 8'hB9,
    8'h05, 8'h7A, 8'hE3, 8'h38, 8'h91, 8'hC6, 8'h1B, 8'h60
  };

  logic [SW-1:0] w_sel;
  assign w_sel = SW'(i_idx);

  always_comb begin
    o_word = '0;
    if (i_idx < (AW+1)'(BOOT_LEN)) o_word = DW'(IMG[w_sel]);
  end
endmodule

// File: rtl/up_memory_mp.sv
// up_memory_mp: single-array memory with one write port and two synchronous
// read ports (instruction fetch + data). After reset it walks every address
// once, loading the boot image (zero beyond INIT_LEN), then raises ready.
// Ports:
//   clk, nRst          clock (rising edge), async active-low reset
//   i_addr/i_data      fetch address in, registered word out
//   i_valid            fetch data valid (RUN only)
//   d_addr/d_wdata     data port address / write data
//   d_we/d_re          write / read request (ignored during INIT)
//   d_rdata            registered read data, held until the next read
//   d_ack              one-cycle completion pulse
//   ready              initialisation complete
//   test               mem[TEST_ADDR] while ready, else 0
module up_memory_mp
  import up_memory_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int INIT_LEN  = BOOT_LEN,
  parameter int TEST_ADDR = 127
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_data,
  output logic          i_valid,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_we,
  input  logic          d_re,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          ready,
  output logic [DW-1:0] test
);
  localparam int            DEPTH = 1 << AW;
  localparam logic [AW-1:0] TA    = AW'(TEST_ADDR);

  state_t        r_state;
  logic [AW:0]   r_init_cnt;  // one extra bit so the terminal count never wraps
  logic          r_ready;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_test;
  logic [DW-1:0] r_idata, r_rdata;
  logic          r_ivalid, r_ack;

  logic          w_run;
  logic [DW-1:0] w_rom, w_init_data;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;

  up_memory_rom #(.DW(DW), .AW(AW)) u_rom (
    .i_idx  (r_init_cnt),
    .o_word (w_rom)
  );

  assign w_run       = (r_state == RUN);
  assign w_init_data = (r_init_cnt < (AW+1)'(INIT_LEN)) ? w_rom : '0;

  // Single write port: the init sequencer owns it during INIT, the data port in RUN.
  assign w_we    = w_run ? d_we   : 1'b1;
  assign w_waddr = w_run ? d_addr : r_init_cnt[AW-1:0];
  assign w_wdata = w_run ? d_wdata : w_init_data;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == (AW+1)'(DEPTH - 1)) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN: r_state <= RUN;
        default: r_state <= INIT;
      endcase
    end
  end

  // Array and its test-word shadow carry no reset so the array maps to block
  // RAM; the INIT walk defines every location before ready is raised.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    if (w_we && (w_waddr == TA)) r_test <= w_wdata;
  end

  // Read ports sample the array before this edge's write lands: read-first.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_idata  <= '0;
      r_rdata  <= '0;
      r_ivalid <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_ivalid <= w_run;
      r_ack    <= w_run && (d_we || d_re);
      if (w_run)         r_idata <= r_mem[i_addr];
      if (w_run && d_re) r_rdata <= r_mem[d_addr];
    end
  end

  assign i_data  = r_idata;
  assign i_valid = r_ivalid;
  assign d_rdata = r_rdata;
  assign d_ack   = r_ack;
  assign ready   = r_ready;
  assign test    = r_ready ? r_test : '0;
endmodule

// File: doc/up_memory_mp.md
UP_MEMORY_MP -- requirements
Module: up_memory_mp

Interface
REQ-001 The block SHALL have parameter DW, default 8, data word width in bits.
REQ-002 The block SHALL have parameter AW, default 8, address width; depth DEPTH = 2**AW.
REQ-003 The block SHALL have parameter INIT_LEN, default 64, number of boot-image words loaded from ROM; INIT_LEN <= DEPTH.
REQ-004 The block SHALL have parameter TEST_ADDR, default 127, word mirrored on the test output.
REQ-005 The block SHALL have port: clk  in  1  clock, all logic on the rising edge.
REQ-006 The block SHALL have port: nRst  in  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port: i_addr  in  AW  instruction fetch address, sampled every cycle.
REQ-008 The block SHALL have port: i_data  out  DW  fetched word.
REQ-009 The block SHALL have port: i_valid  out  1  i_data valid.
REQ-010 The block SHALL have port: d_addr  in  AW  data port address.
REQ-011 The block SHALL have port: d_wdata  in  DW  write data.
REQ-012 The block SHALL have port: d_we  in  1  write request.
REQ-013 The block SHALL have port: d_re  in  1  read request.
REQ-014 The block SHALL have port: d_rdata  out  DW  read data.
REQ-015 The block SHALL have port: d_ack  out  1  one-cycle completion pulse for an accepted request.
REQ-016 The block SHALL have port: ready  out  1  initialisation complete.
REQ-017 The block SHALL have port: test  out  DW  contents of mem[TEST_ADDR].

Function
REQ-018 The block SHALL implement a two-state FSM: INIT, RUN.
REQ-019 INIT: the block SHALL write one word per cycle at init_cnt = 0..DEPTH-1; value = rom[init_cnt] if init_cnt < INIT_LEN, else 0.
REQ-020 INIT->RUN: the transition SHALL occur after the write of DEPTH-1; ready SHALL rise in the cycle after that write and stay 1 until reset.
REQ-021 INIT duration: ready SHALL be low for exactly DEPTH cycles after nRst release.
REQ-022 In INIT, d_we and d_re SHALL be ignored, and d_ack and i_valid SHALL be 0.
REQ-023 In RUN, d_ack SHALL be 1 in cycle N+1 if d_we or d_re was high in cycle N; otherwise it SHALL be 0. There is no back-pressure.
REQ-024 In RUN, a d_re at cycle N SHALL give d_rdata = mem[d_addr] at N+1, registered; d_rdata SHALL hold its value until the next read.
REQ-025 In RUN, a d_we at cycle N SHALL write d_wdata to mem[d_addr] at the N clock edge.
REQ-026 If d_we and d_re are high together, the block SHALL perform the write, and d_rdata SHALL return the pre-write value (read-first).
REQ-027 In RUN, i_data at N+1 SHALL equal mem[i_addr] sampled at N, and i_valid SHALL be 1.
REQ-028 If a fetch and a write target the same address in the same cycle, i_data SHALL return the pre-write value.
REQ-029 test SHALL equal mem[TEST_ADDR] while ready=1, reflecting a write from the cycle after it; test SHALL be 0 while ready=0.
REQ-030 init_cnt SHALL be AW+1 bits wide, so that terminal detection does not wrap.
REQ-031 All addresses SHALL be used modulo DEPTH; no out-of-range condition exists.

Reset
REQ-032 nRst low SHALL immediately force: state=INIT, init_cnt=0, ready=0, i_valid=0, d_ack=0, i_data=0, d_rdata=0.
REQ-033 nRst asserted mid-INIT or mid-RUN SHALL restart initialisation from address 0 on release, discarding all prior contents.
REQ-034 The memory array itself SHALL NOT be reset, so that it can infer to block RAM; its contents SHALL be defined only by the INIT sequence.

Structure
REQ-035 Package up_memory_pkg SHALL hold the DW/AW defaults, the FSM state enum {INIT, RUN} and the boot-image length constant.
REQ-036 Sub-module up_memory_rom SHALL be a combinational ROM indexed by init_cnt, returning the boot image.
REQ-037 The boot image SHALL start with rom[0..5] = 75 5C 69 7F D5 69 (hex).
REQ-038 The memory SHALL be a single array with one write port and two synchronous read ports.

Verification
REQ-039 Release nRst -> ready=0 for exactly 256 cycles, then 1; test=0x00 throughout.
REQ-040 After ready: i_addr=0 -> i_data=0x75 with i_valid=1 next cycle; d_re at d_addr=1 -> d_rdata=0x5C and d_ack=1 next cycle.
REQ-041 d_we d_addr=127 d_wdata=0xA5 -> test=0xA5 next cycle; a following d_re at 127 -> 0xA5.
REQ-042 Same cycle: d_we addr 5 data 0x11, i_addr=5, d_re=1 -> i_data=0x69 and d_rdata=0x69; next fetch of addr 5 -> 0x11.
REQ-043 Pulse nRst at init_cnt=100 -> ready stays 0 for 256 cycles after release; a read of addr 200 afterwards -> 0x00.
REQ-044 d_we addr 70 data 0xFF during INIT -> d_ack=0; after ready, a read of addr 70 -> 0x00.
